// File: rtl/pic_pkg.sv
// Shared definitions for the PIC-style program-flow controller.
// Latency: n/a (constants, types and a pure decode function only).
// Backpressure: n/a.
//
// Holds the counter width, the one-hot Q-phase encodings, the opcode
// match masks/patterns for every control-flow instruction, and the NOP
// encoding. decode_flow() classifies an opcode by its effect on program flow.
package pic_pkg;

    localparam int PC_W = 11;
    localparam int OP_W = 14;

    typedef logic [3:0]      qphase_t;
    typedef logic [OP_W-1:0] opcode_t;

    localparam qphase_t Q1 = 4'b0001;
    localparam qphase_t Q2 = 4'b0010;
    localparam qphase_t Q3 = 4'b0100;
    localparam qphase_t Q4 = 4'b1000;

    // Each instruction matches when (opcode & MASK) == PAT.
    localparam opcode_t GOTO_MASK   = 14'h3800;
    localparam opcode_t GOTO_PAT    = 14'h2800;
    localparam opcode_t CALL_MASK   = 14'h3800;
    localparam opcode_t CALL_PAT    = 14'h2000;
    localparam opcode_t RETURN_MASK = 14'h3FFF;
    localparam opcode_t RETURN_PAT  = 14'h0008;
    localparam opcode_t RETFIE_MASK = 14'h3FFF;
    localparam opcode_t RETFIE_PAT  = 14'h0009;
    localparam opcode_t RETLW_MASK  = 14'h3C00;
    localparam opcode_t RETLW_PAT   = 14'h3400;
    localparam opcode_t BTFSC_MASK  = 14'h3C00;
    localparam opcode_t BTFSC_PAT   = 14'h1800;
    localparam opcode_t BTFSS_MASK  = 14'h3C00;
    localparam opcode_t BTFSS_PAT   = 14'h1C00;
    localparam opcode_t DECFSZ_MASK = 14'h3F00;
    localparam opcode_t DECFSZ_PAT  = 14'h0B00;
    localparam opcode_t INCFSZ_MASK = 14'h3F00;
    localparam opcode_t INCFSZ_PAT  = 14'h0F00;

    localparam opcode_t NOP = 14'h0000;

    typedef enum logic [2:0] {
        FLOW_SEQ  = 3'd0,   // plain fall-through
        FLOW_GOTO = 3'd1,
        FLOW_CALL = 3'd2,
        FLOW_RET  = 3'd3,   // RETURN, RETFIE, RETLW
        FLOW_SKIP = 3'd4    // conditional skip, outcome from the ALU
    } flow_e;

    function automatic logic op_is(input opcode_t op, input opcode_t mask, input opcode_t pat);
        return (op & mask) == pat;
    endfunction

    function automatic flow_e decode_flow(input opcode_t op);
        flow_e f;
        f = FLOW_SEQ;
        if (op_is(op, GOTO_MASK, GOTO_PAT))
            f = FLOW_GOTO;
        else if (op_is(op, CALL_MASK, CALL_PAT))
            f = FLOW_CALL;
        else if (op_is(op, RETURN_MASK, RETURN_PAT) || op_is(op, RETFIE_MASK, RETFIE_PAT) ||
                 op_is(op, RETLW_MASK, RETLW_PAT))
            f = FLOW_RET;
        else if (op_is(op, BTFSC_MASK, BTFSC_PAT) || op_is(op, BTFSS_MASK, BTFSS_PAT) ||
                 op_is(op, DECFSZ_MASK, DECFSZ_PAT) || op_is(op, INCFSZ_MASK, INCFSZ_PAT))
            f = FLOW_SKIP;
        return f;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between the program-flow controller and the rest of the core.
// Latency: n/a (wires only).
// Backpressure: none; the core consumes q/counter/flush every clock.
//
// Ports: opcode/skip flow from the core into the sequencer; q, counter,
// flush and the stack status flow out. master = sequencer, slave = core.
interface pc_sequencer_if #(
    parameter int PC_W        = pic_pkg::PC_W,
    parameter int STACK_DEPTH = 8
);
    localparam int SP_W = $clog2(STACK_DEPTH);

    logic [13:0]     opcode;
    logic            skip;
    logic [3:0]      q;
    logic [PC_W-1:0] counter;
    logic            flush;
    logic [SP_W-1:0] stack_ptr;
    logic            stack_ovf;
    logic            stack_unf;

    modport master (
        input  opcode, skip,
        output q, counter, flush, stack_ptr, stack_ovf, stack_unf
    );

    modport slave (
        output opcode, skip,
        input  q, counter, flush, stack_ptr, stack_ovf, stack_unf
    );
endinterface

// File: rtl/pc_sequencer_call_stack.sv
// Hardware return stack: circular LIFO with occupancy count and sticky ovf/unf.
// Latency: push/pop take effect on the clk edge they are asserted; pop_dat is combinational.
// Backpressure: none; pushing when full overwrites the oldest entry, popping when empty wraps.
//
// Ports: clk, reset (async, active high); push/push_dat, pop/pop_dat;
// stack_ptr (next free slot), stack_ovf, stack_unf.
module call_stack #(
    parameter int PC_W        = 11,
    parameter int STACK_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic [PC_W-1:0]                push_dat,
    input  logic                           pop,
    output logic [PC_W-1:0]                pop_dat,
    output logic [$clog2(STACK_DEPTH)-1:0] stack_ptr,
    output logic                           stack_ovf,
    output logic                           stack_unf
);
    localparam int SP_W  = $clog2(STACK_DEPTH);
    localparam int CNT_W = $clog2(STACK_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(STACK_DEPTH);

    logic [PC_W-1:0]  entry_q [STACK_DEPTH];
    logic [PC_W-1:0]  entry_d [STACK_DEPTH];
    logic [SP_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [SP_W-1:0]  ptr_dec;

    // Depth is a power of two, so pointer arithmetic wraps for free.
    assign ptr_dec = ptr_q - 1'b1;
    // The top entry is always presented; on an empty pop this is the
    // wrapped (stale) entry, which is what the core gets back.
    assign pop_dat = entry_q[ptr_dec];

    always_comb begin
        entry_d = entry_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (push) begin
            entry_d[ptr_q] = push_dat;
            ptr_d          = ptr_q + 1'b1;
            if (count_q == FULL)
                ovf_d = 1'b1;
            else
                count_d = count_q + 1'b1;
        end else if (pop) begin
            ptr_d = ptr_dec;
            if (count_q == '0)
                unf_d = 1'b1;
            else
                count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STACK_DEPTH; i++)
                entry_q[i] <= '0;
            ptr_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            entry_q <= entry_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign stack_ptr = ptr_q;
    assign stack_ovf = ovf_q;
    assign stack_unf = unf_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program-flow controller: Q1..Q4 phase strobes, program counter, branch/skip decode, return stack.
// Latency: counter/flush/stack update once per instruction cycle, on the clk edge ending Q4.
// Backpressure: none; the core runs lock-step with the phase strobes.
//
// Ports: clk, reset (async, active high); bus (master side of pc_sequencer_if):
// opcode/skip in; q, counter, flush, stack_ptr, stack_ovf, stack_unf out.
// Branch targets come from opcode[PC_W-1:0], so PC_W must not exceed 11.
module pc_sequencer #(
    parameter int PC_W         = pic_pkg::PC_W,
    parameter int STACK_DEPTH  = 8,
    parameter int RESET_VECTOR = 0
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.master bus
);
    import pic_pkg::*;

    qphase_t         q_q, q_d;
    logic [PC_W-1:0] counter_q, counter_d;
    logic            flush_q, flush_d;
    logic            end_q4;
    flow_e           flow;
    logic            push, pop;
    logic [PC_W-1:0] pop_dat;
    logic [PC_W-1:0] counter_inc;
    logic [PC_W-1:0] target;

    assign end_q4      = (q_q == Q4);
    assign counter_inc = counter_q + 1'b1;      // wraps modulo 2^PC_W
    assign target      = bus.opcode[PC_W-1:0];

    // An annulled instruction behaves exactly like a NOP: its opcode and
    // the ALU skip flag are never looked at.
    assign flow = flush_q ? FLOW_SEQ : decode_flow(bus.opcode);

    always_comb begin
        q_d       = {q_q[2:0], q_q[3]};
        counter_d = counter_q;
        flush_d   = flush_q;
        push      = 1'b0;
        pop       = 1'b0;
        if (end_q4) begin
            case (flow)
                FLOW_GOTO: begin
                    counter_d = target;
                    flush_d   = 1'b1;
                end
                FLOW_CALL: begin
                    push      = 1'b1;           // counter already holds the return address
                    counter_d = target;
                    flush_d   = 1'b1;
                end
                FLOW_RET: begin
                    pop       = 1'b1;
                    counter_d = pop_dat;
                    flush_d   = 1'b1;
                end
                FLOW_SKIP: begin
                    counter_d = counter_inc;
                    flush_d   = bus.skip;       // annul the already-fetched next instruction
                end
                default: begin
                    counter_d = counter_inc;
                    flush_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q       <= Q1;
            counter_q <= PC_W'(RESET_VECTOR);
            flush_q   <= 1'b1;                  // nothing valid in the pipeline yet
        end else begin
            q_q       <= q_d;
            counter_q <= counter_d;
            flush_q   <= flush_d;
        end
    end

    call_stack #(
        .PC_W        (PC_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_call_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_dat  (counter_q),
        .pop       (pop),
        .pop_dat   (pop_dat),
        .stack_ptr (bus.stack_ptr),
        .stack_ovf (bus.stack_ovf),
        .stack_unf (bus.stack_unf)
    );

    assign bus.q       = q_q;
    assign bus.counter = counter_q;
    assign bus.flush   = flush_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-flow controller for the 4-phase PIC-style core.
- Generates the one-hot Q1..Q4 phase strobes and the 11-bit program counter that addresses the ROM.
- Decodes the executing opcode for control flow: GOTO, CALL, RETURN/RETLW/RETFIE and the conditional skips.
- Owns the hardware return stack.
- Drives a flush strobe that turns the next instruction into a NOP after any taken branch or skip.

Parameters:
PC_W, 11, program counter / ROM address width
STACK_DEPTH, 8, return-stack entries (power of two)
RESET_VECTOR, 0, counter value after reset

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
opcode  input  14  instruction in execute stage; stable for the whole instruction cycle
skip  input  1  skip condition from the ALU (zero result or bit-test true); sampled at the Q4 edge
q  output  4  one-hot phase: 0001=Q1, 0010=Q2, 0100=Q3, 1000=Q4
counter  output  PC_W  ROM fetch address
flush  output  1  current executing instruction is annulled (treat as NOP)
stack_ptr  output  $clog2(STACK_DEPTH)  top-of-stack pointer
stack_ovf  output  1  sticky, set on push into full stack
stack_unf  output  1  sticky, set on pop from empty stack

Behaviour:
- Reset values, applied immediately on reset assertion regardless of phase:
  - q=0001, counter=RESET_VECTOR, flush=1 (pipeline empty), stack_ptr=0.
  - Internal count=0, stack_ovf=0, stack_unf=0.
- Phase: q rotates left one position per clk, 1000 wraps to 0001. One instruction cycle is 4 clk.
- All state except q updates only on the clk edge where q==1000 (end of Q4). counter, flush and stack are stable Q1..Q4.
- During execute of the instruction at address A, counter=A+1 (fetch of the next instruction).
- Decode, applied only when flush==0; with flush==1, opcode and skip are ignored:
  - GOTO (opcode[13:11]=101): counter<=opcode[10:0]; flush<=1.
  - CALL (opcode[13:11]=100): push counter (return address); counter<=opcode[10:0]; flush<=1.
  - RETURN (00_0000_0000_1000), RETFIE (00_0000_0000_1001), RETLW (opcode[13:10]=1101): counter<=pop; flush<=1.
  - BTFSC (opcode[13:10]=0110), BTFSS (0111), DECFSZ (opcode[13:8]=001011), INCFSZ (001111):
    - counter<=counter+1.
    - flush<=skip.
  - Any other instruction: counter<=counter+1; flush<=0.
- Counter increments modulo 2^PC_W: 0x7FF+1 yields 0x000.
- Stack: circular LIFO with separate occupancy count 0..STACK_DEPTH.
  - Push: write entry[stack_ptr]; stack_ptr+1 mod depth.
    - If count<depth, count+1.
    - If count==depth, the oldest entry is overwritten, count stays at depth, stack_ovf<=1.
  - Pop: stack_ptr-1 mod depth; return entry[new stack_ptr].
    - If count>0, count-1.
    - If count==0, count stays 0, stack_unf<=1, and the wrapped entry is still returned.
- stack_ovf and stack_unf clear only on reset.
- Push and pop never occur in the same instruction.
- A skip instruction executing while flush==1 never skips: it is annulled.

Decomposition:
- Shared package pic_pkg holds:
  - PC_W.
  - Q-phase one-hot constants.
  - Opcode match masks and patterns for GOTO, CALL, RETURN, RETFIE, RETLW, BTFSC, BTFSS, DECFSZ, INCFSZ.
  - The NOP encoding.
- One sub-module, call_stack, parameterised by PC_W and STACK_DEPTH, contains:
  - The register array.
  - Pointer, count and push/pop logic.
  - The ovf/unf flags.

Test Plan:
1. Reset, then opcode=14'h0000 continuously:
   - q sequences 0001,0010,0100,1000,0001.
   - counter 0→1→2 at each end-of-Q4.
   - flush=1 only for the first instruction cycle.
2. GOTO 0x123 executed while counter=6:
   - After Q4, counter=0x123 and flush=1 for one cycle.
   - Then counter=0x124, flush=0.
3. CALL 0x040 with counter=0x011, then RETURN:
   - stack_ptr goes 0→1→0.
   - After RETURN, counter=0x011 and flush=1.
4. BTFSC at counter=8:
   - With skip=1 at Q4: counter=9, flush=1.
   - Repeat with skip=0: counter=9, flush=0.
   - A skip instruction with flush=1 and skip=1 gives flush=0 next cycle.
5. Stack boundaries:
   - 9 consecutive CALLs: stack_ovf=1 after the 9th, stack_ptr=1.
   - Then 9 RETURNs: stack_unf=1 on the 9th.
   - Both flags stay 1 until reset.
6. Wrap and reset:
   - GOTO 0x7FF followed by NOP gives counter=0x000.
   - reset asserted mid-Q3 gives q=0001, counter=0, flush=1 in the same time step, without waiting for a clk edge.
